// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
// Holds the occupancy width, default bubble encodings, the IF/ID payload
// struct and the skid stage state encoding.
package pipe_pkg;

  localparam int OCC_W = 2;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [31:0] BUBBLE_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifid_t;

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a 2-entry skid buffer and valid/ready
// handshake. The upstream ready depends only on held state (plus en/rst),
// so there is no combinational path from out_ready to in_ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                global enable, 0 freezes all state
//   flush             drop all held beats and any beat offered this cycle
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
//   occupancy         number of live entries (0..2)
//
// state | meaning
// EMPTY | no live beat, out_data shows last retained value or bubble
// ONE   | main entry live, skid free, upstream may push
// TWO   | main and skid live, upstream held off
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  skid_state_e       state, state_nxt;
  logic [DATA_W-1:0] main_data, main_nxt;
  logic [DATA_W-1:0] skid_data, skid_nxt;
  logic              main_valid, skid_valid;
  logic              push, pop;

  assign main_valid = state[1];
  assign skid_valid = state[0];

  // rst term keeps upstream from seeing acceptance in the reset cycle.
  assign in_ready  = !skid_valid && en && !rst;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= BUBBLE_VAL;
      skid_data <= BUBBLE_VAL;
    end else begin
      state     <= state_nxt;
      main_data <= main_nxt;
      skid_data <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_data;
    skid_nxt  = skid_data;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = BUBBLE_VAL;
    end else if (en) begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_nxt = in_data;
          end else if (push) begin
            state_nxt = TWO;
            skid_nxt  = in_data;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_nxt = ONE;
            main_nxt  = skid_data;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = BUBBLE_VAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_pipe_skid_stage;

  localparam logic [63:0] BUBBLE = 64'h0;

  logic        clk = 1'b0;
  logic        rst, en, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [63:0] in_data, out_data;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO of live beats plus the value shown on out_data.
  logic [63:0] mq[$];
  logic [63:0] m_shown = BUBBLE;

  always #5 clk = ~clk;

  pipe_skid_stage dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  function automatic void model_step();
    int n;
    bit do_pop, do_push;
    if (rst || flush) begin
      mq.delete();
      m_shown = BUBBLE;
    end else if (en) begin
      n       = mq.size();
      do_pop  = (n > 0) && out_ready;
      do_push = in_valid && (n < 2);
      if (do_pop) m_shown = mq.pop_front();
      if (do_push) mq.push_back(in_data);
      if (mq.size() > 0) m_shown = mq[0];
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; en = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0b exp=0", in_ready);
    if (in_ready !== 1'b0) n_fail++;
    cycle();
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== BUBBLE) begin
      $display("FAIL reset_state got v=%0b occ=%0d d=%h exp v=0 occ=0 d=0", out_valid, occupancy, out_data);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_two();
    do_reset();
    in_valid = 1'b1; in_data = 64'h11; cycle();
    in_data = 64'h22; cycle();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (occupancy !== 2'd2) begin
      $display("FAIL mid_two_fill got occ=%0d exp=2", occupancy); n_fail++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL mid_two_rst_ready got=%0b exp=0", in_ready); n_fail++;
    end
    cycle();
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== BUBBLE) begin
      $display("FAIL mid_two_reset got v=%0b occ=%0d d=%h exp v=0 occ=0 d=0", out_valid, occupancy, out_data);
      n_fail++;
    end
    in_valid = 1'b1; in_data = 64'h33; cycle();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || occupancy !== 2'd1 || out_data !== 64'h33) begin
      $display("FAIL mid_two_after got v=%0b occ=%0d d=%h exp v=1 occ=1 d=33", out_valid, occupancy, out_data);
      n_fail++;
    end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 64'(i);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        $display("FAIL stream_ready[%0d] got=%0b exp=1", i, in_ready); n_fail++;
      end
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 64'(i) || occupancy !== 2'd1) begin
        $display("FAIL stream_data[%0d] got v=%0b d=%h occ=%0d exp v=1 d=%h occ=1", i, out_valid, out_data, occupancy, 64'(i));
        n_fail++;
      end
    end
    in_valid = 1'b0;
    cycle();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      $display("FAIL stream_drain got v=%0b occ=%0d exp v=0 occ=0", out_valid, occupancy); n_fail++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1; in_data = 64'hA; cycle();
    in_data = 64'hB; cycle();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 64'hA) begin
      $display("FAIL bp_full got occ=%0d rdy=%0b d=%h exp occ=2 rdy=0 d=a", occupancy, in_ready, out_data);
      n_fail++;
    end
    out_ready = 1'b1;
    cycle();
    n_checks++;
    if (out_data !== 64'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      $display("FAIL bp_second got d=%h occ=%0d rdy=%0b exp d=b occ=1 rdy=1", out_data, occupancy, in_ready);
      n_fail++;
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      $display("FAIL bp_empty got v=%0b occ=%0d exp v=0 occ=0", out_valid, occupancy); n_fail++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_data = 64'hA; cycle();
    in_data = 64'hB; cycle();
    flush = 1'b1; in_data = 64'hC; out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL flush_same_cycle_valid got=%0b exp=1", out_valid); n_fail++;
    end
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== BUBBLE) begin
      $display("FAIL flush_result got v=%0b occ=%0d d=%h exp v=0 occ=0 d=0", out_valid, occupancy, out_data);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL flush_no_leak[%0d] got v=%0b d=%h exp v=0", i, out_valid, out_data); n_fail++;
      end
    end
  endtask

  task automatic test_enable_freeze();
    do_reset();
    in_valid = 1'b1; in_data = 64'h5; cycle();
    en = 1'b0; in_data = 64'h9; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_data !== 64'h5 || occupancy !== 2'd1 || out_valid !== 1'b1) begin
        $display("FAIL freeze[%0d] got rdy=%0b d=%h occ=%0d v=%0b exp rdy=0 d=5 occ=1 v=1", i, in_ready, out_data, occupancy, out_valid);
        n_fail++;
      end
      cycle();
    end
    en = 1'b1; in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h5) begin
      $display("FAIL freeze_resume got v=%0b d=%h exp v=1 d=5", out_valid, out_data); n_fail++;
    end
    cycle();
    n_checks++;
    if (occupancy !== 2'd0) begin
      $display("FAIL freeze_pop got occ=%0d exp=0", occupancy); n_fail++;
    end
  endtask

  task automatic test_push_pop_one();
    do_reset();
    in_valid = 1'b1; in_data = 64'h7; cycle();
    in_data = 64'h8; out_ready = 1'b1; cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++;
    if (out_data !== 64'h8 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      $display("FAIL push_pop_one got d=%h occ=%0d rdy=%0b exp d=8 occ=1 rdy=1", out_data, occupancy, in_ready);
      n_fail++;
    end
  endtask

  task automatic test_random();
    bit          e_valid, e_ready;
    logic [1:0]  e_occ;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      en        = ($urandom_range(0, 7) != 0);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_data   = {$urandom, $urandom};
      #1;
      e_valid = mq.size() > 0;
      e_occ   = 2'(mq.size());
      e_ready = en && !rst && (mq.size() < 2);
      n_checks++;
      if (out_valid !== e_valid || occupancy !== e_occ || out_data !== m_shown || in_ready !== e_ready) begin
        $display("FAIL random[%0d] got v=%0b occ=%0d d=%h rdy=%0b exp v=%0b occ=%0d d=%h rdy=%0b",
                 i, out_valid, occupancy, out_data, in_ready, e_valid, e_occ, m_shown, e_ready);
        n_fail++;
      end
      cycle();
    end
    rst = 1'b0; flush = 1'b0; en = 1'b1; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_two();
    test_streaming();
    test_backpressure();
    test_flush();
    test_enable_freeze();
    test_push_pop_one();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline stage register, the next generation of the fixed IF/ID latch. Sits between any two pipeline stages, e.g. IF->ID or ID->EX.
- Replaces the stall/EN hold scheme with a valid/ready handshake. A 2-entry skid buffer keeps throughput at full rate with a registered upstream ready.
- Adds per-beat valid tracking, flush-to-bubble and an occupancy output for hazard/perf logic.

Parameters:
- DATA_W, 64, payload width in bits (e.g. {PC, inst}).
- BUBBLE_VAL, {DATA_W{1'b0}}, payload loaded on reset/flush (NOP encoding).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable; 0 freezes all state.
- flush  in  1  kill all held beats and any beat offered this cycle.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept; registered, equals !skid_valid && en.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main entry holds a live beat.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main entry payload, driven directly from the register.
- occupancy  out  2  live entries held: 0, 1 or 2.

Behaviour:
- State: main_valid/main_data and skid_valid/skid_data.
  - States: EMPTY (0,0), ONE (1,0), TWO (1,1). The state (0,1) is illegal and must never occur.
- Reset (rst=1, any cycle, including mid-transfer):
  - main_valid=0, skid_valid=0, main_data=BUBBLE_VAL, skid_data=BUBBLE_VAL.
  - Outputs after reset: out_valid=0, in_ready=0 during the rst cycle, occupancy=0, out_data=BUBBLE_VAL.
- Priority: rst > flush > en=0 > handshake.
- Handshake definitions:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
- en=0:
  - No push and no pop occur; all registers hold.
  - in_ready reads 0 combinationally from en, so upstream sees no acceptance.
  - out_valid still reflects main_valid, but pop is ignored.
- flush=1 (with en don't-care):
  - Both valids are cleared next cycle and main_data is set to BUBBLE_VAL.
  - Any same-cycle push is discarded.
  - A same-cycle pop still counts as consumed by downstream: out_valid is 1 that cycle.
- Transitions (en=1, flush=0):
  - EMPTY, push -> ONE; main_data <= in_data.
  - ONE, push & pop -> ONE; main_data <= in_data.
  - ONE, push & !pop -> TWO; skid_data <= in_data.
  - ONE, !push & pop -> EMPTY; main_data retained.
  - TWO, pop -> ONE; main_data <= skid_data. No push is possible because in_ready=0.
  - TWO, !pop -> hold.
- Latency: one cycle from push to out_valid when the stage is empty. Throughput is one beat per cycle while out_ready=1.
- Ordering: strict FIFO. No beat is duplicated or dropped except on flush or reset.
- Data width: payload is opaque. No arithmetic is performed; occupancy = main_valid + skid_valid (2 bits).
- out_data is stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package pipe_pkg:
  - Constant for the occupancy width (2).
  - Default bubble constants: NOP_INST = 32'h00000013, BUBBLE_PC = 32'h0.
  - Typedef for the IF/ID payload struct {pc, inst}, so top-level instantiations set DATA_W=$bits(ifid_t).
- No sub-module: a single module, since the skid logic is only two registers plus a small control path.

Test Plan:
- Reset mid-TWO:
  - Fill with A=0x11, B=0x22, out_ready=0, then assert rst for 1 cycle.
  - Required: out_valid=0, occupancy=0, out_data=0.
  - Next push of 0x33 appears alone.
- Streaming:
  - in_valid=1 and out_ready=1 for 8 cycles with data 1..8.
  - Required: out_data 1..8 on consecutive cycles starting 1 cycle after the first push, in_ready always 1, occupancy=1.
- Backpressure/skid:
  - Push 0xA, 0xB with out_ready=0.
  - Required: occupancy=2, in_ready=0.
  - Then raise out_ready: 0xA then 0xB, in_ready returns to 1 the cycle after 0xA pops.
- Flush with simultaneous push:
  - State TWO(0xA, 0xB), flush=1 with in_valid=1, data 0xC.
  - Required next cycle: out_valid=0, occupancy=0, out_data=BUBBLE_VAL; 0xC never emerges.
- Enable freeze:
  - State ONE(0x5), en=0 for 3 cycles with in_valid=1 and out_ready=1.
  - Required: in_ready=0, out_data=0x5 held, occupancy=1.
  - When en returns to 1, 0x5 pops first.
- Simultaneous push/pop in ONE:
  - Main=0x7, push 0x8 while out_ready=1.
  - Required next cycle: out_data=0x8, occupancy=1, skid_valid stays 0.
